// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Exhaustive stimulus engine for a 1-output combinational block.
//            Walks every input vector, holds each for SETTLE+1 cycles, compares
//            the sampled output against the EXPECT truth table and reports
//            pass/fail, mismatch count and the first failing vector.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int                      N_IN   = 4,
    parameter int                      SETTLE = 0,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_y,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic              fail_seen,
    output logic [N_IN-1:0]   first_fail
);

    localparam logic [1:0]      c_IDLE   = 2'd0;
    localparam logic [1:0]      c_RUN    = 2'd1;
    localparam logic [1:0]      c_DONE   = 2'd2;
    localparam logic [3:0]      c_SETTLE = 4'(SETTLE);
    localparam logic [N_IN-1:0] c_LAST   = {N_IN{1'b1}};

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_idx;
    logic [3:0]      r_hold;
    logic [N_IN:0]   r_err_cnt;
    logic            r_fail_seen;
    logic [N_IN-1:0] r_first_fail;

    logic            w_mismatch;
    logic            w_restart;

    // Compare result for the current vector and restart qualification.
    // A restart is only honoured outside RUN, so start during a sweep is ignored.
    always_comb begin
        w_mismatch = (dut_y != EXPECT[r_idx]);
        w_restart  = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    end

    // Sweep sequencer: vector index, settle counter and result accumulation.
    // abort is checked before the sample/complete branch so it wins both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_hold       <= '0;
            r_err_cnt    <= '0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= '0;
        end else if (w_restart) begin
            r_state      <= c_RUN;
            r_idx        <= '0;
            r_hold       <= '0;
            r_err_cnt    <= '0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= '0;
        end else if (r_state == c_RUN) begin
            if (abort) begin
                r_state      <= c_IDLE;
                r_idx        <= '0;
                r_hold       <= '0;
                r_err_cnt    <= '0;
                r_fail_seen  <= 1'b0;
                r_first_fail <= '0;
            end else if (r_hold < c_SETTLE) begin
                r_hold <= r_hold + 4'd1;
            end else begin
                r_hold <= '0;
                if (w_mismatch) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                    if (!r_fail_seen) begin
                        r_first_fail <= r_idx;
                        r_fail_seen  <= 1'b1;
                    end
                end
                if (r_idx == c_LAST) begin
                    r_state <= c_DONE;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end else if ((r_state != c_IDLE) && (r_state != c_DONE)) begin
            r_state <= c_IDLE;
        end
    end

    // Outputs decode directly from registered state, so they only move at
    // clock edges and all read zero while reset is asserted.
    always_comb begin
        stim       = r_idx;
        busy       = (r_state == c_RUN);
        done       = (r_state == c_DONE);
        pass       = (r_state == c_DONE) && (r_err_cnt == '0);
        err_cnt    = r_err_cnt;
        fail_seen  = r_fail_seen;
        first_fail = r_first_fail;
    end

endmodule
`default_nettype wire
